// File: rtl/dbg_bus_pkg.sv
// -----------------------------------------------------------------------------
// dbg_bus_pkg
// Shared types for the core/debug system-bus arbiter.
//   owner_t     : identifies which master issued a transaction
//   OWNER_CORE  : core load/store port (m0)
//   OWNER_DBG   : debug system-bus-access master (m1)
//   bus_req_t   : request payload layout at the default 32-bit bus widths
//   rr_pick     : round-robin winner for an unlocked arbitration cycle
// -----------------------------------------------------------------------------
package dbg_bus_pkg;

   typedef logic owner_t;

   localparam owner_t OWNER_CORE = 1'b0;
   localparam owner_t OWNER_DBG  = 1'b1;

   localparam int unsigned BUS_ADDR_W = 32;
   localparam int unsigned BUS_DATA_W = 32;

   // Request payload as seen by integration code at the default widths.
   typedef struct packed {
      logic                    we;
      logic [BUS_ADDR_W-1:0]   addr;
      logic [BUS_DATA_W/8-1:0] be;
      logic [BUS_DATA_W-1:0]   wdata;
   } bus_req_t;

   // Round-robin choice: on a tie the master that did not win last time goes
   // first; otherwise the only requester wins. With no requester the result
   // is a don't-care and defaults to the core.
   function automatic owner_t rr_pick(owner_t last, logic req0, logic req1);
      owner_t pick;
      if (req0 && req1) begin
         pick = (last == OWNER_CORE) ? OWNER_DBG : OWNER_CORE;
      end else if (req1) begin
         pick = OWNER_DBG;
      end else begin
         pick = OWNER_CORE;
      end
      return pick;
   endfunction

endpackage

// File: rtl/dbg_bus_owner_fifo.sv
// -----------------------------------------------------------------------------
// dbg_bus_owner_fifo
// In-order record of which master owns each outstanding transaction.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset (clears pointers/count)
//   push         : store push_owner at the tail (ignored when full)
//   push_owner   : owner id of the accepted request
//   pop          : drop the head entry (ignored when empty)
//   head         : owner id at the head (valid when !empty)
//   full, empty  : occupancy flags
// Simultaneous push and pop on a non-empty FIFO advances both pointers and
// leaves the count unchanged.
// -----------------------------------------------------------------------------
module dbg_bus_owner_fifo
   import dbg_bus_pkg::*;
#(
   parameter int unsigned Depth = 2
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   push,
   input  owner_t push_owner,
   input  logic   pop,
   output owner_t head,
   output logic   full,
   output logic   empty
);

   localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntWidth = $clog2(Depth + 1);

   owner_t                mem_q [Depth];
   logic [PtrWidth-1:0]   wr_ptr_q;
   logic [PtrWidth-1:0]   rd_ptr_q;
   logic [CntWidth-1:0]   count_q;
   logic                  do_push;
   logic                  do_pop;

   function automatic logic [PtrWidth-1:0] next_ptr(logic [PtrWidth-1:0] ptr);
      return (ptr == PtrWidth'(Depth - 1)) ? '0 : ptr + PtrWidth'(1);
   endfunction

   assign full    = (count_q == CntWidth'(Depth));
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem_q[rd_ptr_q];

   // Storage needs no reset: entries are only read once the count says so.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_owner;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= next_ptr(wr_ptr_q);
         end
         if (do_pop) begin
            rd_ptr_q <= next_ptr(rd_ptr_q);
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CntWidth'(1);
            2'b01:   count_q <= count_q - CntWidth'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/dbg_bus_arbiter.sv
// -----------------------------------------------------------------------------
// dbg_bus_arbiter
// Shares one memory port between the core data port (m0) and the debug
// system-bus-access master (m1). Zero added latency on request and response.
// Ports:
//   clk, rst_n                          : clock, synchronous active-low reset
//   m0_req/we/addr/be/wdata             : core request
//   m0_gnt, m0_rvalid, m0_rdata         : core grant / response
//   m1_req/we/addr/be/wdata             : debug request
//   m1_gnt, m1_rvalid, m1_rdata         : debug grant / response
//   s_req/we/addr/be/wdata              : request to the slave
//   s_gnt, s_rvalid, s_rdata            : slave grant / response
//   err_o                               : sticky, response with nothing outstanding
//
// Handshake: a master raises req with its payload and holds both stable until
// it sees gnt; the transfer happens in the cycle where req and gnt are both
// high. The slave accepts when s_req & s_gnt, and later returns exactly one
// s_rvalid per accepted request in acceptance order; rdata is meaningful only
// while rvalid is high.
// -----------------------------------------------------------------------------
module dbg_bus_arbiter
   import dbg_bus_pkg::*;
#(
   parameter int unsigned AddrWidth      = 32,
   parameter int unsigned DataWidth      = 32,
   parameter int unsigned MaxOutstanding = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   // core master
   input  logic                   m0_req,
   input  logic                   m0_we,
   input  logic [AddrWidth-1:0]   m0_addr,
   input  logic [DataWidth/8-1:0] m0_be,
   input  logic [DataWidth-1:0]   m0_wdata,
   output logic                   m0_gnt,
   output logic                   m0_rvalid,
   output logic [DataWidth-1:0]   m0_rdata,
   // debug master
   input  logic                   m1_req,
   input  logic                   m1_we,
   input  logic [AddrWidth-1:0]   m1_addr,
   input  logic [DataWidth/8-1:0] m1_be,
   input  logic [DataWidth-1:0]   m1_wdata,
   output logic                   m1_gnt,
   output logic                   m1_rvalid,
   output logic [DataWidth-1:0]   m1_rdata,
   // slave
   output logic                   s_req,
   output logic                   s_we,
   output logic [AddrWidth-1:0]   s_addr,
   output logic [DataWidth/8-1:0] s_be,
   output logic [DataWidth-1:0]   s_wdata,
   input  logic                   s_gnt,
   input  logic                   s_rvalid,
   input  logic [DataWidth-1:0]   s_rdata,
   // status
   output logic                   err_o
);

   localparam int unsigned BeWidth = DataWidth / 8;

   typedef struct packed {
      logic                 we;
      logic [AddrWidth-1:0] addr;
      logic [BeWidth-1:0]   be;
      logic [DataWidth-1:0] wdata;
   } req_pl_t;

   req_pl_t m0_pl;
   req_pl_t m1_pl;
   req_pl_t sel_pl;

   // Arbitration state
   owner_t last_q, last_d;   // master of the last accepted request
   owner_t sel_q,  sel_d;    // master held on s_* while locked
   logic   lock_q, lock_d;   // s_req issued but not yet granted
   owner_t sel;              // master driving s_* this cycle

   logic   sel_req;
   logic   accept;
   logic   pop;
   logic   fifo_full;
   logic   fifo_empty;
   owner_t fifo_head;
   logic   err_q;

   assign m0_pl = '{we: m0_we, addr: m0_addr, be: m0_be, wdata: m0_wdata};
   assign m1_pl = '{we: m1_we, addr: m1_addr, be: m1_be, wdata: m1_wdata};

   // While a request is waiting for s_gnt the selection is frozen so the
   // slave sees a stable request; otherwise round-robin decides.
   always_comb begin
      sel = OWNER_CORE;
      if (lock_q) begin
         sel = sel_q;
      end else begin
         sel = rr_pick(last_q, m0_req, m1_req);
      end
   end

   assign sel_pl  = (sel == OWNER_DBG) ? m1_pl : m0_pl;
   assign sel_req = (sel == OWNER_DBG) ? m1_req : m0_req;

   // Fullness comes only from registered occupancy: a same-cycle s_rvalid
   // does not open a slot, keeping rvalid->req free of combinational paths.
   assign s_req   = rst_n & sel_req & ~fifo_full;
   assign s_we    = sel_pl.we;
   assign s_addr  = sel_pl.addr;
   assign s_be    = sel_pl.be;
   assign s_wdata = sel_pl.wdata;

   assign accept  = s_req & s_gnt;
   assign m0_gnt  = accept & (sel == OWNER_CORE);
   assign m1_gnt  = accept & (sel == OWNER_DBG);

   // Responses go to the owner at the head; a response with nothing
   // outstanding is dropped and flagged.
   assign pop       = rst_n & s_rvalid & ~fifo_empty;
   assign m0_rvalid = pop & (fifo_head == OWNER_CORE);
   assign m1_rvalid = pop & (fifo_head == OWNER_DBG);
   assign m0_rdata  = s_rdata;
   assign m1_rdata  = s_rdata;
   assign err_o     = rst_n & err_q;

   // Next-state for the arbitration state
   always_comb begin
      last_d = last_q;
      sel_d  = sel_q;
      lock_d = lock_q;
      if (accept) begin
         last_d = sel;
      end
      if (s_req) begin
         lock_d = ~s_gnt;
         sel_d  = sel;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_q <= OWNER_DBG;   // core wins the first tie after reset
         sel_q  <= OWNER_CORE;
         lock_q <= 1'b0;
      end else begin
         last_q <= last_d;
         sel_q  <= sel_d;
         lock_q <= lock_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if (s_rvalid && fifo_empty) begin
         err_q <= 1'b1;
      end
   end

   dbg_bus_owner_fifo #(
      .Depth (MaxOutstanding)
   ) u_owner_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (accept),
      .push_owner (sel),
      .pop        (pop),
      .head       (fifo_head),
      .full       (fifo_full),
      .empty      (fifo_empty)
   );

endmodule

// File: tb/tb_dbg_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dbg_bus_arbiter
// Directed scenarios followed by constrained-random traffic. A reference model
// kept as a queue of outstanding owners plus round-robin/lock bookkeeping
// predicts every DUT output each cycle.
// -----------------------------------------------------------------------------
module tb_dbg_bus_arbiter;

   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int BW   = DW / 8;
   localparam int MAXO = 2;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic          m0_req, m0_we, m1_req, m1_we;
   logic [AW-1:0] m0_addr, m1_addr;
   logic [BW-1:0] m0_be, m1_be;
   logic [DW-1:0] m0_wdata, m1_wdata;
   logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
   logic [DW-1:0] m0_rdata, m1_rdata;
   logic          s_req, s_we, s_gnt, s_rvalid;
   logic [AW-1:0] s_addr;
   logic [BW-1:0] s_be;
   logic [DW-1:0] s_wdata, s_rdata;
   logic          err_o;

   dbg_bus_arbiter #(
      .AddrWidth      (AW),
      .DataWidth      (DW),
      .MaxOutstanding (MAXO)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .m0_req    (m0_req),
      .m0_we     (m0_we),
      .m0_addr   (m0_addr),
      .m0_be     (m0_be),
      .m0_wdata  (m0_wdata),
      .m0_gnt    (m0_gnt),
      .m0_rvalid (m0_rvalid),
      .m0_rdata  (m0_rdata),
      .m1_req    (m1_req),
      .m1_we     (m1_we),
      .m1_addr   (m1_addr),
      .m1_be     (m1_be),
      .m1_wdata  (m1_wdata),
      .m1_gnt    (m1_gnt),
      .m1_rvalid (m1_rvalid),
      .m1_rdata  (m1_rdata),
      .s_req     (s_req),
      .s_we      (s_we),
      .s_addr    (s_addr),
      .s_be      (s_be),
      .s_wdata   (s_wdata),
      .s_gnt     (s_gnt),
      .s_rvalid  (s_rvalid),
      .s_rdata   (s_rdata),
      .err_o     (err_o)
   );

   // ---------------- scoreboard / reference model ----------------
   int tests = 0;
   int fails = 0;

   logic [0:0] exp_q[$];      // owners of outstanding transactions, oldest first
   int   m_last     = 1;      // master of last accepted request
   int   m_lock     = 0;      // a request is waiting on s_gnt
   int   m_lock_who = 0;
   int   m_err      = 0;

   int   e_win;
   logic e_sreq, e_g0, e_g1, e_rv0, e_rv1;
   logic prev_g0 = 1'b0;
   logic prev_g1 = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_eval();
      logic full, any_req;
      full = (exp_q.size() >= MAXO);
      if (m_lock != 0)             e_win = m_lock_who;
      else if (m0_req && m1_req)   e_win = 1 - m_last;
      else if (m1_req)             e_win = 1;
      else                         e_win = 0;
      any_req = (e_win == 0) ? m0_req : m1_req;
      e_sreq  = rst_n && any_req && !full;
      e_g0    = e_sreq && s_gnt && (e_win == 0);
      e_g1    = e_sreq && s_gnt && (e_win == 1);
      e_rv0   = rst_n && s_rvalid && (exp_q.size() > 0) && (exp_q[0] == 1'b0);
      e_rv1   = rst_n && s_rvalid && (exp_q.size() > 0) && (exp_q[0] == 1'b1);
   endtask

   task automatic model_commit();
      if (!rst_n) begin
         exp_q.delete();
         m_last = 1;
         m_lock = 0;
         m_err  = 0;
      end else begin
         if (s_rvalid) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            else                  m_err = 1;
         end
         if (e_sreq && s_gnt) begin
            exp_q.push_back(1'(e_win));
            m_last = e_win;
         end
         if (e_sreq) begin
            m_lock     = s_gnt ? 0 : 1;
            m_lock_who = e_win;
         end
      end
   endtask

   // Let inputs settle mid-cycle, predict and compare every output.
   task automatic settle();
      #2;
      model_eval();
      chk("s_req",     s_req,     e_sreq);
      chk("m0_gnt",    m0_gnt,    e_g0);
      chk("m1_gnt",    m1_gnt,    e_g1);
      chk("m0_rvalid", m0_rvalid, e_rv0);
      chk("m1_rvalid", m1_rvalid, e_rv1);
      chk("err_o",     err_o,     (rst_n && m_err != 0) ? 1'b1 : 1'b0);
      if (e_sreq) begin
         chk("s_addr",  s_addr,  (e_win == 1) ? m1_addr  : m0_addr);
         chk("s_we",    s_we,    (e_win == 1) ? m1_we    : m0_we);
         chk("s_be",    s_be,    (e_win == 1) ? m1_be    : m0_be);
         chk("s_wdata", s_wdata, (e_win == 1) ? m1_wdata : m0_wdata);
      end
      if (e_rv0 || e_rv1) begin
         chk("m0_rdata", m0_rdata, s_rdata);
         chk("m1_rdata", m1_rdata, s_rdata);
      end
      prev_g0 = e_g0;
      prev_g1 = e_g1;
   endtask

   task automatic step_edge();
      @(posedge clk);
      model_commit();
      #1;
   endtask

   task automatic cycle();
      settle();
      step_edge();
   endtask

   // ---------------- driver tasks ----------------
   task automatic idle_inputs();
      m0_req = 0; m0_we = 0; m0_addr = '0; m0_be = '0; m0_wdata = '0;
      m1_req = 0; m1_we = 0; m1_addr = '0; m1_be = '0; m1_wdata = '0;
      s_gnt = 0; s_rvalid = 0; s_rdata = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 0;
      cycle();
      rst_n = 1;
   endtask

   task automatic rand_master0();
      if (prev_g0) m0_req = 0;
      if (!m0_req && $urandom_range(0, 99) < 55) begin
         m0_req   = 1;
         m0_we    = 1'($urandom_range(0, 1));
         m0_addr  = $urandom;
         m0_be    = BW'($urandom_range(0, 15));
         m0_wdata = $urandom;
      end
   endtask

   task automatic rand_master1();
      if (prev_g1) m1_req = 0;
      if (!m1_req && $urandom_range(0, 99) < 55) begin
         m1_req   = 1;
         m1_we    = 1'($urandom_range(0, 1));
         m1_addr  = $urandom;
         m1_be    = BW'($urandom_range(0, 15));
         m1_wdata = $urandom;
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      idle_inputs();
      rst_n = 0;
      #1;
      cycle();
      cycle();
      rst_n = 1;

      // Solo core read
      m0_req = 1; m0_addr = 32'h1000; s_gnt = 1;
      settle();
      chk("solo_gnt", m0_gnt, 1'b1);
      step_edge();
      m0_req = 0; s_gnt = 0; s_rvalid = 1; s_rdata = 32'hDEADBEEF;
      settle();
      chk("solo_rvalid",  m0_rvalid, 1'b1);
      chk("solo_rdata",   m0_rdata,  32'hDEADBEEF);
      chk("solo_m1_rval", m1_rvalid, 1'b0);
      step_edge();
      s_rvalid = 0;

      // Contention from reset: grants alternate m0,m1,m0,m1
      do_reset();
      m0_addr = 32'h1000; m1_addr = 32'h2000;
      for (int i = 0; i < 5; i++) begin
         m0_req   = (i < 4);
         m1_req   = (i < 4);
         s_gnt    = (i < 4);
         s_rvalid = (i > 0);
         s_rdata  = DW'(i);
         settle();
         if (i < 4) begin
            chk("cont_m0_gnt", m0_gnt, (i % 2 == 0) ? 1'b1 : 1'b0);
            chk("cont_m1_gnt", m1_gnt, (i % 2 == 1) ? 1'b1 : 1'b0);
         end
         if (i > 0) begin
            chk("cont_m0_rv", m0_rvalid, (i % 2 == 1) ? 1'b1 : 1'b0);
            chk("cont_m1_rv", m1_rvalid, (i % 2 == 0) ? 1'b1 : 1'b0);
         end
         step_edge();
      end
      idle_inputs();

      // Lock: m1 waits 3 cycles without s_gnt while m0 also requests
      do_reset();
      m1_req = 1; m1_addr = 32'h2000; m0_addr = 32'h1000;
      for (int i = 0; i < 3; i++) begin
         m0_req = (i > 0);
         settle();
         chk("lock_addr", s_addr, 32'h2000);
         chk("lock_sreq", s_req,  1'b1);
         step_edge();
      end
      s_gnt = 1;
      settle();
      chk("lock_m1_gnt", m1_gnt, 1'b1);
      chk("lock_m0_gnt", m0_gnt, 1'b0);
      step_edge();
      m1_req = 0;
      settle();
      chk("lock_m0_next", m0_gnt, 1'b1);
      step_edge();
      m0_req = 0; s_gnt = 0; s_rvalid = 1; s_rdata = 32'hA1;
      settle();
      chk("lock_rv_m1", m1_rvalid, 1'b1);
      step_edge();
      s_rdata = 32'hA2;
      settle();
      chk("lock_rv_m0", m0_rvalid, 1'b1);
      step_edge();
      idle_inputs();

      // Full: two grants, then s_req held off until a response has drained
      do_reset();
      m0_req = 1; m0_addr = 32'h3000; s_gnt = 1;
      cycle();
      cycle();
      settle();
      chk("full_sreq", s_req, 1'b0);
      step_edge();
      s_rvalid = 1; s_rdata = 32'h11;
      settle();
      chk("full_sreq_rv", s_req, 1'b0);
      step_edge();
      s_rvalid = 0;
      settle();
      chk("full_reissue", s_req, 1'b1);
      step_edge();
      m0_req = 0; s_gnt = 0; s_rvalid = 1;
      cycle();
      cycle();
      idle_inputs();

      // Spurious response
      do_reset();
      s_rvalid = 1; s_rdata = 32'h55;
      settle();
      chk("spur_m0_rv", m0_rvalid, 1'b0);
      chk("spur_m1_rv", m1_rvalid, 1'b0);
      step_edge();
      s_rvalid = 0;
      settle();
      chk("spur_err", err_o, 1'b1);
      step_edge();
      cycle();
      settle();
      chk("spur_err_sticky", err_o, 1'b1);
      step_edge();
      rst_n = 0;
      settle();
      chk("spur_err_rst", err_o, 1'b0);
      step_edge();
      rst_n = 1;
      settle();
      chk("spur_err_clr", err_o, 1'b0);
      step_edge();

      // Reset mid-flight
      m0_req = 1; m0_addr = 32'h4000; s_gnt = 1;
      cycle();
      rst_n = 0;
      settle();
      chk("mid_rst_sreq", s_req,  1'b0);
      chk("mid_rst_gnt",  m0_gnt, 1'b0);
      step_edge();
      rst_n = 1; m0_req = 0; s_gnt = 0; s_rvalid = 1;
      settle();
      chk("mid_late_rv", m0_rvalid, 1'b0);
      step_edge();
      s_rvalid = 0;
      settle();
      chk("mid_late_err", err_o, 1'b1);
      step_edge();

      // Random traffic with one reset in the middle
      do_reset();
      for (int i = 0; i < 400; i++) begin
         rst_n = (i == 200) ? 1'b0 : 1'b1;
         rand_master0();
         rand_master1();
         s_gnt    = 1'($urandom_range(0, 1));
         s_rvalid = (exp_q.size() > 0) && ($urandom_range(0, 99) < 50);
         s_rdata  = $urandom;
         cycle();
      end
      idle_inputs();
      rst_n = 1;
      cycle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/dbg_bus_arbiter.md
# dbg_bus_arbiter

Two-master, one-slave arbiter that lets the core data port and the debug module's system-bus-access master (`sb_*`) share a single memory port using req/gnt/rvalid signalling. It sits between the CPU load/store unit, the debug wrapper's system bus outputs, and the memory/interconnect slave. It adds zero cycles on the request path. It tracks outstanding transactions in order, so each `rvalid`/`rdata` is returned only to the master that issued it.

## Interface
Parameters:
- `AddrWidth`, 32, address width of all ports
- `DataWidth`, 32, data width; byte-enable width is `DataWidth/8`
- `MaxOutstanding`, 2, accepted-but-unanswered transactions allowed (≥1)

Ports:
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: reset; synchronous, active-low
- `m0_req/m0_we` in 1, `m0_addr` in AddrWidth, `m0_be` in DataWidth/8, `m0_wdata` in DataWidth: core request
- `m0_gnt` out 1, `m0_rvalid` out 1, `m0_rdata` out DataWidth: core grant/response
- `m1_req/m1_we/m1_addr/m1_be/m1_wdata` in: debug SBA request (same widths as m0)
- `m1_gnt`, `m1_rvalid`, `m1_rdata` out: debug SBA grant/response
- `s_req/s_we` out 1, `s_addr` out AddrWidth, `s_be` out DataWidth/8, `s_wdata` out DataWidth: to slave
- `s_gnt` in 1, `s_rvalid` in 1, `s_rdata` in DataWidth: from slave
- `err_o` out 1: sticky; set when `s_rvalid` arrives with no outstanding transaction

## Operation
- Handshake: a request is accepted in a cycle where `s_req & s_gnt` is true. A master holds `req` and its payload stable until it receives `gnt`. Exactly one `rvalid` is returned per accepted request, in acceptance order.
- Arbitration is round-robin. `last_q` (1 bit) records the master of the last accepted request.
  - Both masters requesting, no lock: the master ≠ `last_q` wins.
  - One master requesting: that master wins.
- Lock: once `s_req` is driven for master X without `s_gnt`, `lock_q` is set and `sel_q`=X. Selection stays on X until X is granted. The other master cannot preempt, which keeps `s_*` stable as the slave protocol requires.
- Selected payload is muxed combinationally onto `s_*`. The unselected master sees `gnt`=0.
- `s_req` = selected `req` & (`count_q` < MaxOutstanding). When full, no request is issued, regardless of a same-cycle `s_rvalid`. There is no rvalid→req combinational path.
- `m*_gnt` = `s_gnt` & `s_req` & selected.
- On accept, the owner id is pushed into the owner FIFO.
- On `s_rvalid`: pop the FIFO head, then assert `m<head>_rvalid` and drive `m<head>_rdata` = `s_rdata` in the same cycle. The other master's `rvalid` is 0. `rdata` is driven to all masters; it is qualified only by `rvalid`.
- Simultaneous push and pop: `count_q` is unchanged, and the FIFO pointers both advance.
- `s_rvalid` with `count_q`=0: the response is dropped (no `m*_rvalid`), and `err_o` is set to 1 until reset.
- Reset mid-operation: the FIFO is cleared, and outstanding responses are forgotten. Late `rvalid` after reset therefore sets `err_o`. The slave is expected to be reset together with the arbiter.

## Timing
- Request path: 0 cycles (combinational `req`→`s_req`, `s_gnt`→`m_gnt`).
- Response path: 0 cycles (combinational `s_rvalid`→`m_rvalid`).
- Registered state: `last_q`, `lock_q`, `sel_q`, FIFO entries and pointers, `count_q` (width clog2(MaxOutstanding+1)), `err_q`. All update on `clk` rising edge.
- Reset values: `last_q`=1 (so m0 wins the first tie), `lock_q`=0, `count_q`=0, `err_o`=0.
- While `rst_n`=0, all outputs are forced to 0: `s_req`, `m*_gnt`, `m*_rvalid`, `err_o`.
- Throughput: one accepted request per cycle while not full.
- With MaxOutstanding=1, at most one request is in flight. The next request can be issued in the cycle after `rvalid`.

## Structure
- Package `dbg_bus_pkg`:
  - `typedef logic owner_t` with constants `OWNER_CORE`=0 and `OWNER_DBG`=1
  - request struct `bus_req_t` (`we`, `addr`, `be`, `wdata`)
- Sub-module `dbg_bus_owner_fifo`: depth MaxOutstanding, width 1, push/pop/full/empty/head. It has synchronous active-low reset and supports simultaneous push+pop when non-empty.
- Arbiter core (select/lock/round-robin) lives in `dbg_bus_arbiter`.

## Test plan
- Solo core read: m0 reads 0x1000, `s_gnt` same cycle, `s_rvalid` next cycle with 0xDEADBEEF → `m0_gnt` in cycle 0; `m0_rvalid`=1 and `m0_rdata`=0xDEADBEEF in cycle 1; `m1_rvalid` stays 0.
- Contention from reset: both request every cycle with `s_gnt`=1 → accepted order m0, m1, m0, m1. Responses with rdata 1,2,3,4 are routed m0,m1,m0,m1.
- Lock: m1 requests and `s_gnt` is held 0 for 3 cycles while m0 also requests → `s_addr` stays at m1's address for all 3 cycles. m1 is granted on cycle 4, and m0 is granted on cycle 5.
- Full: MaxOutstanding=2, two grants, no rvalid → `s_req`=0 despite m0 `req`. After one `rvalid`, `s_req` reasserts the next cycle.
- Spurious response: `s_rvalid`=1 with nothing outstanding → no `m*_rvalid`, `err_o`=1 from the next cycle, cleared only by `rst_n`=0.
- Reset mid-flight: one transaction outstanding, then `rst_n` low for 1 cycle → `count_q`=0 and outputs 0 during reset. A subsequent `s_rvalid` sets `err_o`.
